fetch_ctrl: RTL and testbench

- Sequences instruction fetch: owns the fetch PC, issues word reads to Instruction Memory and buffers returned words in a small queue.
- Hands instructions to Instruction Decode with a valid/ready handshake.
- Applies redirects from branch resolution by flushing the queue and dropping in-flight reads.
- Mirrors the PC to the special registers through the existing wr_pc/wr_pc_val write port.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} pairs.
module fetch_queue #(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_instr,
    input  logic          pop,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output logic [31:0]   head_pc,
    output logic [31:0]   head_instr
);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_pc    = head_valid ? pc_q[rd_ptr] : '0;
    assign head_instr = head_valid ? instr_q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && (count == CW'(DEPTH)) && !pop));
            if (do_push) begin
                pc_q[wr_ptr]    <= push_pc;
                instr_q[wr_ptr] <= push_instr;
                wr_ptr          <= bump(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues IM reads, queues words for decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        wr_pc,
    output logic [31:0] wr_pc_val
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic          inflight;
    logic          discard;
    logic [CW-1:0] q_count;
    logic          pop;
    logic          issue;
    logic          take_redirect;
    logic          push;

    assign pop = id_valid && id_ready;

    assign issue = !reset && (state != HALTED) && !halt && !redirect
                 && ((int'(q_count) + int'(inflight)) < (DEPTH + int'(pop)));

    // halt outranks redirect, and a halted unit ignores redirects entirely
    assign take_redirect = redirect && !halt && (state != HALTED);
    assign push          = inflight && !discard && !take_redirect;

    assign im_req    = issue;
    assign im_addr   = fetch_pc;
    assign wr_pc     = issue;
    assign wr_pc_val = issue ? fetch_pc + PC_STEP : fetch_pc;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (halt)
                    state_nxt = HALTED;
                else if (redirect)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (halt)
                    state_nxt = HALTED;
                else if (redirect)
                    state_nxt = FLUSH;
                else
                    state_nxt = RUN;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            discard  <= take_redirect ? inflight : 1'b0;
            if (issue)
                resp_pc <= fetch_pc;
            if (take_redirect)
                fetch_pc <= word_align(redirect_pc);
            else if (issue)
                fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (resp_pc),
        .push_instr (im_data),
        .pop        (pop),
        .clear      (take_redirect),
        .count      (q_count),
        .head_valid (id_valid),
        .head_pc    (id_pc),
        .head_instr (id_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with an in-order pc scoreboard.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        wr_pc;
    logic [31:0] wr_pc_val;

    logic        reset2;
    logic        im_req2;
    logic [31:0] im_addr2;
    logic [31:0] im_data2;
    logic        id_valid2;
    logic        id_ready2;
    logic [31:0] id_instr2;
    logic [31:0] id_pc2;
    logic        wr_pc2;
    logic [31:0] wr_pc_val2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        halt2;

    int tests;
    int fails;

    logic [31:0] sbq[$];
    logic [31:0] exp_pc;
    bit          halted_m;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    fetch_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .wr_pc       (wr_pc),
        .wr_pc_val   (wr_pc_val)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk         (clk),
        .reset       (reset2),
        .im_req      (im_req2),
        .im_addr     (im_addr2),
        .im_data     (im_data2),
        .id_valid    (id_valid2),
        .id_ready    (id_ready2),
        .id_instr    (id_instr2),
        .id_pc       (id_pc2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .halt        (halt2),
        .wr_pc       (wr_pc2),
        .wr_pc_val   (wr_pc_val2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        im_data  <= instr_of(im_addr);
        im_data2 <= instr_of(im_addr2);
    end

    // scoreboard: issues push expected pcs, ID handshakes pop and compare
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (reset) begin
            sbq.delete();
            exp_pc   = 32'h0;
            halted_m = 1'b0;
        end else begin
            if (id_valid && id_ready) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra: id_pc=%h presented, nothing expected", id_pc);
                end else begin
                    e = sbq.pop_front();
                    if (id_pc !== e || id_instr !== instr_of(e)) begin
                        fails++;
                        $display("FAIL sb_order: got pc=%h instr=%h, want pc=%h instr=%h",
                                 id_pc, id_instr, e, instr_of(e));
                    end
                end
            end
            tests++;
            if (im_req) begin
                if (halted_m || im_addr !== exp_pc || wr_pc !== 1'b1
                    || wr_pc_val !== exp_pc + 32'd4) begin
                    fails++;
                    $display("FAIL sb_issue: got addr=%h wr_pc=%b val=%h halted=%b, want addr=%h val=%h",
                             im_addr, wr_pc, wr_pc_val, halted_m, exp_pc, exp_pc + 32'd4);
                end
                sbq.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end else if (wr_pc !== 1'b0) begin
                fails++;
                $display("FAIL sb_wr_pc: got wr_pc=%b without im_req, want 0", wr_pc);
            end
            if (halt)
                halted_m = 1'b1;
            else if (redirect && !halted_m) begin
                sbq.delete();
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    task automatic cyc(input logic rst, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic hl);
        @(negedge clk);
        reset       = rst;
        id_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        tests += 7;
        if (im_req !== 1'b0) begin fails++; $display("FAIL rst_im_req: got %b want 0", im_req); end
        if (im_addr !== 32'h0) begin fails++; $display("FAIL rst_im_addr: got %h want 0", im_addr); end
        if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
        if (id_instr !== 32'h0) begin fails++; $display("FAIL rst_id_instr: got %h want 0", id_instr); end
        if (id_pc !== 32'h0) begin fails++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
        if (wr_pc !== 1'b0) begin fails++; $display("FAIL rst_wr_pc: got %b want 0", wr_pc); end
        if (wr_pc_val !== 32'h0) begin fails++; $display("FAIL rst_wr_pc_val: got %h want 0", wr_pc_val); end
    endtask

    task automatic test_stream;
        cyc(0, 1, 0, 0, 0);
        tests += 3;
        if (im_req !== 1'b1 || im_addr !== 32'h0) begin
            fails++; $display("FAIL stream_first_issue: got req=%b addr=%h want 1/0", im_req, im_addr);
        end
        if (wr_pc_val !== 32'h4) begin fails++; $display("FAIL stream_wr_pc_val: got %h want 4", wr_pc_val); end
        if (id_valid !== 1'b0) begin fails++; $display("FAIL stream_c0_valid: got %b want 0", id_valid); end
        cyc(0, 1, 0, 0, 0);
        tests += 2;
        if (im_addr !== 32'h4) begin fails++; $display("FAIL stream_c1_addr: got %h want 4", im_addr); end
        if (id_valid !== 1'b0) begin fails++; $display("FAIL stream_c1_valid: got %b want 0", id_valid); end
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            fails++; $display("FAIL stream_latency: got valid=%b pc=%h want 1/0", id_valid, id_pc);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0, 0);
            tests++;
            if (id_valid !== 1'b1 || im_req !== 1'b1) begin
                fails++; $display("FAIL stream_rate: cycle %0d valid=%b req=%b want 1/1", i, id_valid, im_req);
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] hp, hi;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (i == 0) begin
                hp = id_pc;
                hi = id_instr;
            end
            tests++;
            if (id_valid !== 1'b1 || id_pc !== hp || id_instr !== hi || im_req !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d valid=%b pc=%h instr=%h req=%b want 1/%h/%h/0",
                         i, id_valid, id_pc, id_instr, im_req, hp, hi);
            end
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_redirect;
        cyc(0, 1, 1, 32'h0000_0103, 0);
        tests++;
        if (im_req !== 1'b0) begin fails++; $display("FAIL redir_n_req: got %b want 0", im_req); end
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (im_req !== 1'b1 || im_addr !== 32'h100 || id_valid !== 1'b0) begin
            fails++; $display("FAIL redir_target: got req=%b addr=%h valid=%b want 1/100/0", im_req, im_addr, id_valid);
        end
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (id_valid !== 1'b0) begin fails++; $display("FAIL redir_n2_valid: got %b want 0", id_valid); end
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== instr_of(32'h100)) begin
            fails++; $display("FAIL redir_n3_head: got valid=%b pc=%h want 1/100", id_valid, id_pc);
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_halt;
        int pops;
        pops = 0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h200, 1);
        tests++;
        if (im_req !== 1'b0) begin fails++; $display("FAIL halt_req: got %b want 0", im_req); end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, (i == 0 || i == 3), 32'h300, 0);
            if (id_valid && id_ready) pops++;
            tests++;
            if (im_req !== 1'b0 || wr_pc !== 1'b0) begin
                fails++; $display("FAIL halt_quiet: cycle %0d req=%b wr_pc=%b want 0/0", i, im_req, wr_pc);
            end
        end
        tests += 2;
        if (pops !== 2) begin fails++; $display("FAIL halt_drain: got %0d pops want 2", pops); end
        if (id_valid !== 1'b0) begin fails++; $display("FAIL halt_empty: got valid=%b want 0", id_valid); end
    endtask

    task automatic test_reset_stall;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        tests++;
        if (id_valid !== 1'b0 || wr_pc !== 1'b0 || im_addr !== 32'h0 || im_req !== 1'b0) begin
            fails++; $display("FAIL rst_mid: got valid=%b wr_pc=%b addr=%h req=%b want 0/0/0/0",
                              id_valid, wr_pc, im_addr, im_req);
        end
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (im_req !== 1'b1 || im_addr !== 32'h0) begin
            fails++; $display("FAIL rst_restart: got req=%b addr=%h want 1/0", im_req, im_addr);
        end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            fails++; $display("FAIL rst_first_head: got valid=%b pc=%h want 1/0", id_valid, id_pc);
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_wrap;
        @(negedge clk);
        reset2 = 1'b0;
        #1;
        tests++;
        if (im_req2 !== 1'b1 || im_addr2 !== 32'hFFFF_FFF8 || wr_pc_val2 !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL wrap_c0: got req=%b addr=%h val=%h want 1/fffffff8/fffffffc",
                              im_req2, im_addr2, wr_pc_val2);
        end
        @(negedge clk);
        #1;
        tests++;
        if (im_addr2 !== 32'hFFFF_FFFC || wr_pc_val2 !== 32'h0) begin
            fails++; $display("FAIL wrap_c1: got addr=%h val=%h want fffffffc/0", im_addr2, wr_pc_val2);
        end
        @(negedge clk);
        #1;
        tests++;
        if (im_addr2 !== 32'h0 || id_valid2 !== 1'b1 || id_pc2 !== 32'hFFFF_FFF8
            || id_instr2 !== instr_of(32'hFFFF_FFF8)) begin
            fails++; $display("FAIL wrap_c2: got addr=%h valid=%b pc=%h want 0/1/fffffff8",
                              im_addr2, id_valid2, id_pc2);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        exp_pc       = 32'h0;
        halted_m     = 1'b0;
        reset        = 1'b1;
        id_ready     = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        halt         = 1'b0;
        reset2       = 1'b1;
        id_ready2    = 1'b1;
        redirect2    = 1'b0;
        redirect_pc2 = 32'h0;
        halt2        = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_reset_stall();
        test_wrap();
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
